// File: rtl/ltl_cluster_sequencer.sv
// Sequences one LTL monitor cluster over bounded symbol windows and queues its report events.
// Latency: symbol accepted in cycle N drives the cluster in N+1; its reports are captured in N+2.
// Backpressure: sym_ready is held low unless the event queue has room for everything in flight.
module ltl_cluster_sequencer #(
    parameter int SYM_W       = 8,
    parameter int NUM_REPORTS = 4,
    parameter int CNT_W       = 16,
    parameter int EVQ_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       cfg_len,
    input  logic                   sym_valid,
    input  logic [SYM_W-1:0]       sym_data,
    output logic                   sym_ready,
    output logic                   auto_reset,
    output logic                   auto_run,
    output logic [SYM_W-1:0]       auto_symbols,
    input  logic [NUM_REPORTS-1:0] auto_reports,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [NUM_REPORTS-1:0] ev_mask,
    output logic [CNT_W-1:0]       ev_index,
    output logic [NUM_REPORTS-1:0] sticky_mask,
    output logic                   busy,
    output logic                   done
);
    localparam int PW = $clog2(EVQ_DEPTH);
    // Highest occupancy that still leaves room for two in-flight slots plus a new accept.
    localparam logic [PW:0] Q_LIM = (PW+1)'(EVQ_DEPTH - 3);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic             phase;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] sym_idx;
    logic             p1_vld, p2_vld;
    logic [CNT_W-1:0] p1_idx, p2_idx;

    logic [NUM_REPORTS-1:0] q_mask [EVQ_DEPTH];
    logic [CNT_W-1:0]       q_idx  [EVQ_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;

    logic start_act, abort_act, accept, push, pop;

    assign start_act = (state == S_IDLE) && start && !abort;
    assign abort_act = abort && ((state == S_ARM) || (state == S_STREAM) || (state == S_DRAIN));
    assign sym_ready = (state == S_STREAM) && (remaining != '0) && (count <= Q_LIM);
    assign accept    = sym_valid && sym_ready;
    assign push      = p2_vld && (auto_reports != '0) && !abort_act;
    assign ev_valid  = (count != '0);
    assign pop       = ev_valid && ev_ready;
    assign ev_mask   = q_mask[rd_ptr];
    assign ev_index  = q_idx[rd_ptr];
    assign auto_reset = (state == S_IDLE) || (state == S_ARM);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: ARM and DRAIN each last two cycles, tracked by phase.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_act) state_nxt = S_ARM;
            S_ARM:    if (abort_act) state_nxt = S_IDLE;
                      else if (phase) state_nxt = (remaining == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: if (abort_act) state_nxt = S_IDLE;
                      else if (accept && (remaining == CNT_W'(1))) state_nxt = S_DRAIN;
            S_DRAIN:  if (abort_act) state_nxt = S_IDLE;
                      else if (phase) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Window bookkeeping, cluster drive and the two-stage report pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= 1'b0;
            remaining    <= '0;
            sym_idx      <= '0;
            auto_run     <= 1'b0;
            auto_symbols <= '0;
            p1_vld       <= 1'b0;
            p2_vld       <= 1'b0;
            p1_idx       <= '0;
            p2_idx       <= '0;
            sticky_mask  <= '0;
        end else begin
            phase    <= ((state == S_ARM) || (state == S_DRAIN)) && !phase && !abort_act;
            auto_run <= accept && !abort_act;
            p1_vld   <= accept && !abort_act;
            p1_idx   <= sym_idx;
            p2_vld   <= p1_vld && !abort_act;
            p2_idx   <= p1_idx;
            if (accept) auto_symbols <= sym_data;
            if (start_act) begin
                remaining   <= cfg_len;
                sym_idx     <= '0;
                sticky_mask <= '0;
            end else begin
                if (accept) begin
                    remaining <= remaining - CNT_W'(1);
                    sym_idx   <= sym_idx + CNT_W'(1);
                end
                if (push) sticky_mask <= sticky_mask | auto_reports;
            end
        end
    end

    // Event queue pointers and occupancy; persists across windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Event queue storage.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mask[wr_ptr] <= auto_reports;
            q_idx[wr_ptr]  <= p2_idx;
        end
    end
endmodule

// File: tb/tb_ltl_cluster_sequencer.sv
// Randomized and directed bench for ltl_cluster_sequencer with a transaction-level scoreboard.
// The bench plays the cluster: reports for a symbol appear two cycles after its accept.
// Expected events/sticky mask come from per-symbol report choices, not from DUT internals.
module tb_ltl_cluster_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, abort, sym_valid, ev_ready;
    logic [15:0] cfg_len;
    logic [7:0]  sym_data;
    logic [3:0]  auto_reports;
    logic        sym_ready, auto_reset, auto_run, ev_valid, busy, done;
    logic [7:0]  auto_symbols;
    logic [3:0]  ev_mask, sticky_mask;
    logic [15:0] ev_index;

    ltl_cluster_sequencer #(.SYM_W(8), .NUM_REPORTS(4), .CNT_W(16), .EVQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_len(cfg_len),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .auto_reset(auto_reset), .auto_run(auto_run), .auto_symbols(auto_symbols),
        .auto_reports(auto_reports), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_mask(ev_mask), .ev_index(ev_index), .sticky_mask(sticky_mask),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] mask; logic [15:0] idx; } ev_t;
    typedef struct { logic vld; logic [7:0] sym; logic [3:0] rep; logic [15:0] idx; } slot_t;

    ev_t         exp_ev[$];
    slot_t       st1, st2;
    logic [3:0]  exp_sticky;
    logic [15:0] win_idx;
    int          mode;
    int          ntests = 0, nfail = 0, cyc = 0;
    int          n_arm, n_run, n_done, n_drain, n_acc, n_pop, last_run_cyc, done_cyc, max_q;
    logic [3:0]  last_pop_mask;
    logic [15:0] last_pop_idx;
    logic [7:0]  tab [3];
    logic        directed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] pick(input int m, input logic [15:0] k);
        case (m)
            1:       return ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            2:       return (k == 16'd1) ? 4'b0001 : 4'b0000;
            3:       return 4'($urandom_range(1, 15));
            default: return 4'd0;
        endcase
    endfunction

    task automatic clear_stats();
        n_arm = 0; n_run = 0; n_done = 0; n_drain = 0; n_acc = 0; n_pop = 0;
        last_run_cyc = 0; done_cyc = 0;
    endtask

    // One clock cycle: sample at mid-cycle, score, advance the model, then present cluster reports.
    task automatic step();
        logic acc, pop;
        #4;
        acc = sym_valid && sym_ready;
        pop = ev_valid && ev_ready;
        check("auto_run", auto_run, st1.vld);
        if (st1.vld) check("auto_symbols", auto_symbols, st1.sym);
        check("ev_valid", ev_valid, exp_ev.size() != 0);
        if (pop && exp_ev.size() != 0) begin
            check("ev_mask", ev_mask, exp_ev[0].mask);
            check("ev_index", ev_index, exp_ev[0].idx);
            last_pop_mask = ev_mask;
            last_pop_idx  = ev_index;
            void'(exp_ev.pop_front());
            n_pop++;
        end
        check("sticky_mask", sticky_mask, exp_sticky);
        if (auto_run === 1'b1) begin n_run++; last_run_cyc = cyc; end
        if (done === 1'b1) begin n_done++; done_cyc = cyc; end
        if (busy && auto_reset) n_arm++;
        if (busy && !auto_reset && !done) n_drain++;
        if (acc) n_acc++;
        if (st2.vld && !abort && st2.rep != 4'd0) begin
            exp_ev.push_back('{mask: st2.rep, idx: st2.idx});
            exp_sticky = exp_sticky | st2.rep;
        end
        if (exp_ev.size() > max_q) max_q = exp_ev.size();
        if (start && !abort) begin exp_sticky = 4'd0; win_idx = 16'd0; end
        st2 = st1;
        st2.vld = st1.vld && !abort;
        st1.vld = acc && !abort;
        st1.sym = sym_data;
        st1.idx = win_idx;
        st1.rep = acc ? pick(mode, win_idx) : 4'd0;
        if (acc) win_idx = win_idx + 16'd1;
        @(posedge clk); #1;
        cyc++;
        auto_reports = st2.vld ? st2.rep : 4'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; sym_valid = 1'b0; ev_ready = 1'b0;
        @(posedge clk); #1;
        exp_ev.delete();
        st1 = '{default: '0}; st2 = '{default: '0};
        exp_sticky = 4'd0; win_idx = 16'd0;
        auto_reports = 4'($urandom);
        #3;
        check("rst_auto_reset", auto_reset, 1);
        check("rst_auto_run", auto_run, 0);
        check("rst_auto_symbols", auto_symbols, 0);
        check("rst_sym_ready", sym_ready, 0);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_sticky", sticky_mask, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        cyc++;
    endtask

    // Start a window and feed it until the done pulse or the cycle budget runs out.
    task automatic run_window(input int len, input int vprob, input int rprob, input int m);
        int guard;
        mode = m; cfg_len = 16'(len); start = 1'b1;
        clear_stats();
        step();
        start = 1'b0;
        guard = 0;
        while (n_done == 0 && guard < 400) begin
            sym_valid = ($urandom_range(0, 99) < vprob);
            sym_data  = (directed && n_acc < 3) ? tab[n_acc] : 8'($urandom);
            ev_ready  = ($urandom_range(0, 99) < rprob);
            step();
            guard++;
        end
        sym_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        sym_valid = 1'b0; ev_ready = 1'b1;
        guard = 0;
        while (exp_ev.size() != 0 && guard < 40) begin step(); guard++; end
        step();
        check("drain_empty", ev_valid, 0);
    endtask

    initial begin
        tab[0] = 8'h05; tab[1] = 8'h15; tab[2] = 8'h85;
        directed = 1'b0; mode = 0; max_q = 0;
        cfg_len = 16'd0; sym_data = 8'd0; auto_reports = 4'd0;
        clear_stats();
        do_reset();

        // Basic three-symbol window with a single report on the second symbol.
        directed = 1'b1;
        run_window(3, 100, 100, 2);
        directed = 1'b0;
        check("t1_done_seen", n_done, 1);
        check("t1_arm_cycles", n_arm, 2);
        check("t1_run_cycles", n_run, 3);
        check("t1_done_after_run", done_cyc - last_run_cyc, 2);
        check("t1_event_count", n_pop, 1);
        check("t1_event_mask", last_pop_mask, 4'b0001);
        check("t1_event_index", last_pop_idx, 16'd1);
        step();
        check("t1_sticky", sticky_mask, 4'b0001);
        check("t1_idle", busy, 0);

        // Empty window: arm, drain, done, never run.
        run_window(0, 100, 100, 0);
        check("t2_done_seen", n_done, 1);
        check("t2_arm_cycles", n_arm, 2);
        check("t2_drain_cycles", n_drain, 2);
        check("t2_no_run", n_run, 0);

        // Queue backpressure: reports on every symbol with the consumer stalled.
        mode = 3; cfg_len = 16'd10; start = 1'b1; clear_stats(); max_q = 0;
        step();
        start = 1'b0; sym_valid = 1'b1; ev_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin sym_data = 8'($urandom); step(); end
        check("t3_stalled_ready", sym_ready, 0);
        check("t3_stalled_busy", busy, 1);
        check("t3_queue_full", max_q, 4);
        ev_ready = 1'b1;
        for (int i = 0; i < 60 && n_done == 0; i++) begin sym_data = 8'($urandom); step(); end
        sym_valid = 1'b0;
        drain();
        check("t3_done_seen", n_done, 1);
        check("t3_accepts", n_acc, 10);
        check("t3_no_loss", n_pop, 10);

        // Abort after two accepts: in-flight reports must not reach the queue.
        mode = 3; cfg_len = 16'd8; start = 1'b1; clear_stats();
        step();
        start = 1'b0; sym_valid = 1'b1; ev_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 2; i++) begin sym_data = 8'($urandom); step(); end
        sym_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_idle_after_abort", busy, 0);
        check("t5_auto_reset", auto_reset, 1);
        for (int i = 0; i < 6; i++) step();
        check("t5_no_done", n_done, 0);
        check("t5_no_events", n_pop, 0);
        check("t5_sticky_kept_zero", sticky_mask, 0);

        // Start and abort together from IDLE: start is ignored.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("t6_start_abort_idle", busy, 0);
        step();

        // Reset in the middle of a window with events queued.
        mode = 3; cfg_len = 16'd8; start = 1'b1; clear_stats();
        step();
        start = 1'b0; sym_valid = 1'b1; ev_ready = 1'b0;
        for (int i = 0; i < 30 && exp_ev.size() < 2; i++) begin sym_data = 8'($urandom); step(); end
        check("t7_two_queued", exp_ev.size(), 2);
        do_reset();

        // Random windows with random valid/ready and sparse reports.
        for (int w = 0; w < 6; w++) begin
            int len;
            len = $urandom_range(1, 12);
            run_window(len, 70, 60, 1);
            check("rand_done", n_done, 1);
            check("rand_accepts", n_acc, len);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
